// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain
//   Pops words from the read side of a TX FIFO and serialises each one as a
//   UART frame: start bit, DBIT data bits LSB first, then stop bit(s) lasting
//   SB_TICK oversample ticks. A private divider produces one oversample tick
//   every DVSR clocks; each start/data bit spans 16 ticks.
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high
//   fifo_empty   FIFO empty flag
//   fifo_r_data  FIFO head word (valid while fifo_empty=0)
//   fifo_rd      one-clock pop strobe, only issued from IDLE
//   tx           serial line, idle high, registered
//   tx_busy      high while a frame is in progress
//   tx_done_tick one-clock pulse on the last clock of the stop period
module uart_tx_fifo_drain #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_r_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_next;
  logic [DVSR_W-1:0] div, div_next;
  logic [TW-1:0]     tick, tick_next;
  logic [BW-1:0]     bitc, bitc_next;
  logic [DBIT-1:0]   shift, shift_next;
  logic              tx_reg, tx_next;
  logic              s_tick;

  assign s_tick  = (div == DVSR_W'(DVSR - 1));
  assign tx      = tx_reg;
  assign tx_busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      div    <= '0;
      tick   <= '0;
      bitc   <= '0;
      shift  <= '0;
      tx_reg <= 1'b1;
    end else begin
      state  <= state_next;
      div    <= div_next;
      tick   <= tick_next;
      bitc   <= bitc_next;
      shift  <= shift_next;
      tx_reg <= tx_next;
    end
  end

  always_comb begin
    state_next   = state;
    tick_next    = tick;
    bitc_next    = bitc;
    shift_next   = shift;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;

    // Divider runs freely across START/DATA/STOP so bit boundaries stay
    // exactly 16*DVSR clocks apart; it only restarts from IDLE.
    if (state == IDLE)
      div_next = '0;
    else if (s_tick)
      div_next = '0;
    else
      div_next = div + DVSR_W'(1);

    case (state)
      IDLE: begin
        if (!fifo_empty && !reset) begin
          fifo_rd    = 1'b1;
          shift_next = fifo_r_data;
          tick_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick == TW'(15)) begin
            tick_next  = '0;
            bitc_next  = '0;
            state_next = DATA;
          end else begin
            tick_next = tick + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick == TW'(15)) begin
            tick_next  = '0;
            shift_next = shift >> 1;
            if (bitc == BW'(DBIT - 1))
              state_next = STOP;
            else
              bitc_next = bitc + BW'(1);
          end else begin
            tick_next = tick + TW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick == TW'(SB_TICK - 1)) begin
            tick_next    = '0;
            tx_done_tick = 1'b1;
            state_next   = IDLE;
          end else begin
            tick_next = tick + TW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is derived from the next state so tx moves on the same
    // edge as the state register.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain (DVSR=4 -> 64 clocks per bit).
// A queue stands in for the FIFO; a UART receiver model decodes the line and
// compares each frame with the scoreboard. A second instance checks SB_TICK=32.
module tb_uart_tx_fifo_drain;

  localparam int DVSR  = 4;
  localparam int BIT   = 16 * DVSR;
  localparam int FRAME = 10 * BIT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_r_data = '0;
  logic       fifo_rd, tx, tx_busy, tx_done_tick;

  logic       fifo_empty32 = 1'b1;
  logic [7:0] fifo_r_data32 = '0;
  logic       fifo_rd32, tx32, tx_busy32, tx_done_tick32;

  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16), .DVSR(DVSR), .DVSR_W(3)) u_dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data),
    .fifo_rd(fifo_rd), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick));

  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(32), .DVSR(DVSR), .DVSR_W(3)) u_dut32 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty32), .fifo_r_data(fifo_r_data32),
    .fifo_rd(fifo_rd32), .tx(tx32), .tx_busy(tx_busy32), .tx_done_tick(tx_done_tick32));

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  logic [7:0] sb_q[$];
  int passed = 0, total = 0;
  int rd_count = 0, rd_viol = 0, done_total = 0, frames_total = 0, pushes_total = 0;
  bit mon_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push(input logic [7:0] d, input bit scored);
    fifo_q.push_back(d);
    if (scored) sb_q.push_back(d);
    pushes_total++;
  endtask

  // FIFO model: pop on a sampled fifo_rd, present head (or junk when empty).
  initial begin : fifo_drv
    logic rd_s, rd_prev;
    rd_prev = 1'b0;
    forever begin
      @(negedge clk);
      rd_s = fifo_rd;
      if (tx_done_tick) done_total++;
      if (rd_s) begin
        rd_count++;
        if (fifo_empty || tx_busy || rd_prev || reset) rd_viol++;
      end
      rd_prev = rd_s;
      @(posedge clk);
      #1;
      if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_empty = (fifo_q.size() == 0);
      if (fifo_empty) fifo_r_data = 8'($urandom);
      else            fifo_r_data = fifo_q[0];
    end
  end

  // Receiver model: capture a whole frame from its first low sample.
  initial begin : monitor
    logic smp [FRAME];
    bit   b2b;
    b2b = 1'b0;
    forever begin
      @(negedge clk);
      if (b2b) check("b2b_start", tx, 1'b0);
      b2b = 1'b0;
      if (mon_en && !reset && tx === 1'b0) begin
        logic [7:0] got, exp;
        logic lvl;
        int line_err, busy_err, done_cnt, done_idx;
        line_err = 0; busy_err = 0; done_cnt = 0; done_idx = -1;
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) @(negedge clk);
          smp[k] = tx;
          if (tx_busy !== 1'b1) busy_err++;
          if (tx_done_tick) begin done_cnt++; done_idx = k; end
        end
        for (int i = 0; i < 8; i++) got[i] = smp[BIT * (i + 1) + BIT / 2];
        for (int k = 0; k < FRAME; k++) begin
          if (k < BIT)          lvl = 1'b0;
          else if (k < 9 * BIT) lvl = got[(k - BIT) / BIT];
          else                  lvl = 1'b1;
          if (smp[k] !== lvl) line_err++;
        end
        frames_total++;
        if (sb_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_frame: got %02h expected no frame", got);
        end else begin
          exp = sb_q.pop_front();
          check("frame_data", got, exp);
        end
        check("frame_line", line_err, 0);
        check("frame_busy", busy_err, 0);
        check("done_count", done_cnt, 1);
        check("done_pos", done_idx, FRAME - 1);
        @(negedge clk);
        check("idle_tx", tx, 1'b1);
        check("idle_busy", tx_busy, 1'b0);
        check("idle_pop", fifo_rd, !fifo_empty);
        b2b = !fifo_empty;
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || fifo_q.size() != 0 || tx_busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      total++;
      $display("FAIL %s_timeout: got %0d frames pending expected 0", name, sb_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (!tx_busy && n < 10) begin @(negedge clk); n++; end
    check({name, "_busy_rise"}, tx_busy, 1'b1);
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: got no finish expected finish before 3ms");
    $fatal(1);
  end

  initial begin : main
    int r0, p0, bad, d0, busy_n, low_n, done_n, done_at, rd_n;

    // Reset with a word arriving in the FIFO while reset is still high.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", tx_busy, 1'b0);
      check("rst_rd", fifo_rd, 1'b0);
      if (c == 1) push(8'h55, 1'b1);
    end
    @(posedge clk); #1 reset = 1'b0;
    drain("t2");
    check("t2_pops", rd_count, 1);

    r0 = rd_count;
    push(8'hA3, 1'b1);
    push(8'h0F, 1'b1);
    drain("t3");
    check("t3_pops", rd_count - r0, 2);
    check("t3_fifo_empty", fifo_q.size(), 0);

    r0 = rd_count;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    drain("t4");
    check("t4_pops", rd_count - r0, 16);

    r0 = rd_count;
    p0 = pushes_total;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) push(8'($urandom), 1'b1);
      repeat ($urandom_range(0, 1500)) @(negedge clk);
    end
    drain("rand");
    check("rand_pops", rd_count - r0, pushes_total - p0);

    // Reset mid-frame (data phase of 0xFF), then idle with FIFO empty.
    mon_en = 1'b0;
    d0 = done_total;
    push(8'hFF, 1'b0);
    wait_busy("t5");
    repeat (300) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("t5_tx", tx, 1'b1);
    check("t5_busy", tx_busy, 1'b0);
    check("t5_done", tx_done_tick, 1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_rd !== 1'b0 || tx_done_tick !== 1'b0) bad++;
    end
    check("t5_quiet", bad, 0);
    check("t5_no_done", done_total - d0, 0);
    check("t5_word_lost", fifo_q.size(), 0);

    // Reset during the start bit: line must jump high at once.
    push(8'h00, 1'b0);
    wait_busy("t5b");
    repeat (10) @(negedge clk);
    check("t5b_low", tx, 1'b0);
    #1 reset = 1'b1;
    #1;
    check("t5b_tx", tx, 1'b1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    check("t5b_idle", tx_busy, 1'b0);
    mon_en = 1'b1;

    // Two stop bits: 128-clock stop, 704-clock frame for 0x00.
    @(posedge clk); #1;
    fifo_empty32  = 1'b0;
    fifo_r_data32 = 8'h00;
    @(negedge clk);
    check("t6_pop", fifo_rd32, 1'b1);
    @(posedge clk); #1;
    fifo_empty32  = 1'b1;
    fifo_r_data32 = 8'hFF;
    busy_n = 0; low_n = 0; done_n = 0; done_at = -1; rd_n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (tx_busy32) busy_n++;
      if (!tx32) low_n++;
      if (fifo_rd32) rd_n++;
      if (tx_done_tick32) begin done_n++; done_at = k; end
    end
    check("t6_busy_len", busy_n, 704);
    check("t6_low_len", low_n, 9 * BIT);
    check("t6_done_count", done_n, 1);
    check("t6_done_pos", done_at, 703);
    check("t6_no_pop", rd_n, 0);

    check("done_vs_frames", done_total, frames_total);
    check("rd_violations", rd_viol, 0);
    check("pops_vs_pushes", rd_count, pushes_total);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
